n64_vtiming_detect: RTL and testbench



---
 rtl/n64_vtiming_detect.sv | 131 +++++++++++++
 tb/tb_n64_vtiming_detect.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/n64_vtiming_detect.sv
// N64 video timing detector: colour-phase counter, sync-nibble decode, 240p/480i and PAL/NTSC detection.
// All outputs registered (1 VCLK); optional N64_VTIMING_HYSTERESIS_EN requires two agreeing fields before a mode flag changes.
module n64_vtiming_detect #(
  parameter int COLOR_W    = 7,
  parameter int LINE_CNT_W = 10,
  parameter int PAL_THRESH = 288
) (
  input  logic                  VCLK,
  input  logic                  nRST,
  input  logic                  nDSYNC,
  input  logic [COLOR_W-1:0]    D_i,
  output logic [1:0]            data_cnt,
  output logic                  n64_480i,
  output logic                  palmode,
  output logic                  field_id,
  output logic                  new_frame,
  output logic [LINE_CNT_W-1:0] lines_last
);

  logic [1:0]            r_data_cnt;
  logic [3:0]            r_prev_sync;
  logic [LINE_CNT_W-1:0] r_line_cnt;
  logic [LINE_CNT_W-1:0] r_lines_last;
  logic                  r_field_id;
  logic                  r_last_field;
  logic                  r_new_frame;
  logic                  r_armed;
  logic                  r_pal;
  logic                  r_480i;
`ifdef N64_VTIMING_HYSTERESIS_EN
  logic                  r_pal_pend;
  logic                  r_480i_pend;
`endif

  logic                  w_sync_vld;
  logic                  w_nvsync;
  logic                  w_nhsync;
  logic                  w_vs_fall;
  logic                  w_hs_fall;
  logic [LINE_CNT_W-1:0] w_line_inc;
  logic [LINE_CNT_W-1:0] w_field_lines;
  logic                  w_pal_raw;
  logic                  w_i_raw;
  logic                  w_decide;
  logic                  w_unused;

  // Sync nibble on !nDSYNC cycles: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  assign w_sync_vld = ~nDSYNC;
  assign w_nvsync   = D_i[3];
  assign w_nhsync   = D_i[1];
  assign w_vs_fall  = w_sync_vld & r_prev_sync[3] & ~w_nvsync;
  assign w_hs_fall  = w_sync_vld & r_prev_sync[1] & ~w_nhsync;

  assign w_line_inc    = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + 1'b1;
  // A line edge coinciding with the frame edge still belongs to the field just ended
  assign w_field_lines = w_hs_fall ? w_line_inc : r_line_cnt;
  assign w_pal_raw     = (w_field_lines >= LINE_CNT_W'(PAL_THRESH));
  assign w_i_raw       = w_nhsync ^ r_field_id;
  assign w_decide      = w_vs_fall & r_armed;

  assign w_unused = ^{D_i[COLOR_W-1:4], D_i[2], D_i[0], r_prev_sync[2], r_prev_sync[0], r_last_field};

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      r_data_cnt   <= 2'd0;
      r_prev_sync  <= 4'hF;
      r_line_cnt   <= '0;
      r_lines_last <= '0;
      r_field_id   <= 1'b0;
      r_last_field <= 1'b0;
      r_new_frame  <= 1'b0;
      r_armed      <= 1'b0;
      r_pal        <= 1'b0;
      r_480i       <= 1'b0;
`ifdef N64_VTIMING_HYSTERESIS_EN
      r_pal_pend   <= 1'b0;
      r_480i_pend  <= 1'b0;
`endif
    end else begin
      r_data_cnt  <= nDSYNC ? r_data_cnt + 2'd1 : 2'd1;
      r_new_frame <= w_vs_fall;

      if (w_sync_vld)
        r_prev_sync <= D_i[3:0];

      if (w_vs_fall) begin
        r_lines_last <= w_field_lines;
        r_line_cnt   <= '0;
        r_field_id   <= w_nhsync;
        r_last_field <= r_field_id;
        r_armed      <= 1'b1;
      end else if (w_hs_fall) begin
        r_line_cnt   <= w_line_inc;
      end

      // The partial field seen right after reset never drives a decision
      if (w_decide) begin
`ifdef N64_VTIMING_HYSTERESIS_EN
        if (w_pal_raw == r_pal) begin
          r_pal_pend <= 1'b0;
        end else if (r_pal_pend) begin
          r_pal      <= w_pal_raw;
          r_pal_pend <= 1'b0;
        end else begin
          r_pal_pend <= 1'b1;
        end

        if (w_i_raw == r_480i) begin
          r_480i_pend <= 1'b0;
        end else if (r_480i_pend) begin
          r_480i      <= w_i_raw;
          r_480i_pend <= 1'b0;
        end else begin
          r_480i_pend <= 1'b1;
        end
`else
        r_pal  <= w_pal_raw;
        r_480i <= w_i_raw;
`endif
      end
    end
  end

  assign data_cnt   = r_data_cnt;
  assign n64_480i   = r_480i;
  assign palmode    = r_pal;
  assign field_id   = r_field_id;
  assign new_frame  = r_new_frame;
  assign lines_last = r_lines_last;

endmodule

// File: tb/tb_n64_vtiming_detect.sv
// Randomized bench for n64_vtiming_detect: stimulus built from fields of known line count and parity,
// expectations derived from those field parameters rather than from the sync waveform.
module tb_n64_vtiming_detect;

  localparam int COLOR_W    = 7;
  localparam int LINE_CNT_W = 10;
  localparam int PAL_THRESH = 288;

  logic                  VCLK;
  logic                  nRST;
  logic                  nDSYNC;
  logic [COLOR_W-1:0]    D_i;
  logic [1:0]            data_cnt;
  logic                  n64_480i;
  logic                  palmode;
  logic                  field_id;
  logic                  new_frame;
  logic [LINE_CNT_W-1:0] lines_last;

  n64_vtiming_detect #(
    .COLOR_W    (COLOR_W),
    .LINE_CNT_W (LINE_CNT_W),
    .PAL_THRESH (PAL_THRESH)
  ) dut (
    .VCLK       (VCLK),
    .nRST       (nRST),
    .nDSYNC     (nDSYNC),
    .D_i        (D_i),
    .data_cnt   (data_cnt),
    .n64_480i   (n64_480i),
    .palmode    (palmode),
    .field_id   (field_id),
    .new_frame  (new_frame),
    .lines_last (lines_last)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  int cyc = 0;
  int anchor_cyc = 0;
  int anchor_val = 0;
  int exp_ll = 0;
  int exp_fid = 0;
  int exp_pal = 0;
  int exp_i = 0;
  int exp_nf = 0;
  int n_ev = 0;
  int pal_streak = 0;
  int i_streak = 0;
  int lines_since = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic reset_model();
    exp_ll = 0; exp_fid = 0; exp_pal = 0; exp_i = 0; exp_nf = 0;
    n_ev = 0; pal_streak = 0; i_streak = 0; lines_since = 0;
  endtask

  // Flag update for one field's raw decisions
  task automatic decide(input int pal_raw, input int i_raw);
`ifdef N64_VTIMING_HYSTERESIS_EN
    if (pal_raw != exp_pal) begin
      pal_streak++;
      if (pal_streak == 2) begin exp_pal = pal_raw; pal_streak = 0; end
    end else pal_streak = 0;
    if (i_raw != exp_i) begin
      i_streak++;
      if (i_streak == 2) begin exp_i = i_raw; i_streak = 0; end
    end else i_streak = 0;
`else
    exp_pal = pal_raw;
    exp_i   = i_raw;
`endif
  endtask

  // A field ends: its line count is the lines drawn plus one if hsync falls with vsync
  task automatic frame_model(input int p);
    int cnt;
    cnt = lines_since + ((p == 0) ? 1 : 0);
    lines_since = 0;
    n_ev++;
    exp_ll = cnt;
    if (n_ev >= 2) decide((cnt >= PAL_THRESH) ? 1 : 0, (p != exp_fid) ? 1 : 0);
    exp_fid = p;
  endtask

  task automatic step(input logic rst_n, input logic nd, input logic [COLOR_W-1:0] d, input int ev);
    nRST = rst_n; nDSYNC = nd; D_i = d;
    @(posedge VCLK); #1;
    cyc++;
    if (!rst_n) begin
      anchor_cyc = cyc; anchor_val = 0; reset_model();
    end else if (!nd) begin
      anchor_cyc = cyc; anchor_val = 1;
    end
    exp_nf = (rst_n && ev != 0) ? 1 : 0;
    check_eq("data_cnt",   32'(data_cnt),   32'((anchor_val + cyc - anchor_cyc) % 4));
    check_eq("new_frame",  32'(new_frame),  32'(exp_nf));
    check_eq("lines_last", 32'(lines_last), 32'(exp_ll));
    check_eq("field_id",   32'(field_id),   32'(exp_fid));
    check_eq("palmode",    32'(palmode),    32'(exp_pal));
    check_eq("n64_480i",   32'(n64_480i),   32'(exp_i));
  endtask

  // One sync cycle then `gap` colour cycles (gap<0: usually 3, occasionally early/late)
  task automatic sample(input logic vs, input logic hs, input int ev, input int gap);
    logic [COLOR_W-1:0] d;
    int g;
    d = COLOR_W'($urandom);
    d[3] = vs;
    d[1] = hs;
    if (ev != 0) frame_model(hs ? 1 : 0);
    step(1'b1, 1'b0, d, ev);
    g = gap;
    if (g < 0) g = ($urandom_range(15) == 0) ? int'($urandom_range(5, 1)) : 3;
    repeat (g) step(1'b1, 1'b1, COLOR_W'($urandom), 0);
  endtask

  task automatic line();
    lines_since++;
    sample(1'b1, 1'b0, 0, -1);
    sample(1'b1, 1'b1, 0, -1);
  endtask

  task automatic field(input int n_lines, input int p);
    repeat (n_lines) line();
    sample(1'b0, p[0], 1, -1);
    sample(1'b0, 1'b1, 0, -1);
    sample(1'b1, 1'b1, 0, -1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; nDSYNC = 1'b1; D_i = '0;

    // Reset state, including reset winning over a simultaneous nDSYNC
    step(1'b0, 1'b1, '0, 0);
    step(1'b0, 1'b0, 7'h7F, 0);

    // Steady 4-cycle phase with idle sync
    repeat (4) sample(1'b1, 1'b1, 0, 3);
    // Early and late nDSYNC
    sample(1'b1, 1'b1, 0, 1);
    sample(1'b1, 1'b1, 0, 5);
    sample(1'b1, 1'b1, 0, 3);

    // 240p NTSC
    repeat (3) field(263, 1);
    // 480i PAL: 312/313 alternating with parity toggle
    field(312, 1);
    field(312, 0);
    field(312, 1);
    field(312, 0);
    // Frame edge with no line in between
    field(0, 1);
    field(0, 1);

    // 240p with a single parity glitch, then persistent toggling
    repeat (3) field(40, 1);
    field(40, 0);
    field(40, 0);
    field(40, 1);
    field(40, 0);
    field(40, 1);

    // Reset mid-field after 100 lines
    repeat (100) line();
    step(1'b0, 1'b1, COLOR_W'($urandom), 0);
    step(1'b0, 1'b0, COLOR_W'($urandom), 0);
    field(int'($urandom_range(120, 10)), 1);
    field(int'($urandom_range(330, 290)), 0);
    field(int'($urandom_range(330, 290)), 1);

    // Random fields
    for (int k = 0; k < 12; k++)
      field(int'($urandom_range(300, 0)), int'($urandom_range(1, 0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
